// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : detector_jogada
//  Description : Player push-button input stage. Synchronizes and debounces
//                the raw button vector, then validates each press: a single
//                one-hot press while enabled yields a one-cycle tem_jogada
//                strobe with a registered jogada code; simultaneous presses
//                yield a one-cycle multipla strobe instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_jogada #(
    parameter int N_BOTOES = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                multipla,
    output logic [3:0]          db_estado
);

    localparam int              c_CW      = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE - 1);

    localparam logic [2:0] c_LIVRE    = 3'd0;
    localparam logic [2:0] c_ESPERA   = 3'd1;
    localparam logic [2:0] c_EMITE    = 3'd2;
    localparam logic [2:0] c_MULTIPLA = 3'd3;
    localparam logic [2:0] c_SOLTURA  = 3'd4;

    logic [N_BOTOES-1:0] r_s1;
    logic [N_BOTOES-1:0] r_s2;
    logic [N_BOTOES-1:0] r_amostra;
    logic [c_CW-1:0]     r_cnt;
    logic [N_BOTOES-1:0] r_filtrado;
    logic [2:0]          r_estado;
    logic [2:0]          w_proximo;
    logic [N_BOTOES-1:0] r_jogada;

    logic w_zero;
    logic w_unico;
    logic w_livre_ok;
    logic w_captura;

    assign w_zero  = (r_filtrado == '0);
    assign w_unico = !w_zero && ((r_filtrado & (r_filtrado - 1'b1)) == '0);

    // LIVRE only trusts a zero filtered vector once the debouncer has itself
    // confirmed a stable all-released sample. Right after reset filtrado is 0
    // regardless of the buttons, so a button held across reset must first be
    // seen pressed and then released before a new play can be accepted.
    assign w_livre_ok = w_zero && (r_amostra == '0) && (r_cnt == c_CNT_MAX);

    assign w_captura = (r_estado == c_ESPERA) && !w_zero && habilita && w_unico;

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= botoes;
            r_s2 <= r_s1;
        end
    end

    // Whole-vector debounce: any change restarts the stable-cycle count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_amostra  <= '0;
            r_cnt      <= '0;
            r_filtrado <= '0;
        end else if (r_s2 != r_amostra) begin
            r_amostra <= r_s2;
            r_cnt     <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_filtrado <= r_amostra;
        end
    end

    // Next-state logic of the press-validation FSM
    always_comb begin
        w_proximo = c_LIVRE;
        case (r_estado)
            c_LIVRE:    w_proximo = w_livre_ok ? c_ESPERA : c_LIVRE;
            c_ESPERA: begin
                if (w_zero)         w_proximo = c_ESPERA;
                else if (!habilita) w_proximo = c_LIVRE;
                else if (w_unico)   w_proximo = c_EMITE;
                else                w_proximo = c_MULTIPLA;
            end
            c_EMITE:    w_proximo = c_SOLTURA;
            c_MULTIPLA: w_proximo = c_LIVRE;
            c_SOLTURA:  w_proximo = w_zero ? c_ESPERA : c_SOLTURA;
            default:    w_proximo = c_LIVRE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_estado <= c_LIVRE;
        else          r_estado <= w_proximo;
    end

    // Captured play, written only when a valid single press is accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       r_jogada <= '0;
        else if (w_captura) r_jogada <= r_filtrado;
    end

    // Moore output decode and debug state code
    always_comb begin
        tem_jogada = (r_estado == c_EMITE);
        multipla   = (r_estado == c_MULTIPLA);
        db_estado  = 4'hF;
        case (r_estado)
            c_LIVRE, c_ESPERA, c_EMITE, c_MULTIPLA, c_SOLTURA: db_estado = {1'b0, r_estado};
            default:                                          db_estado = 4'hF;
        endcase
    end

    assign jogada = r_jogada;

endmodule
`default_nettype wire
